// File: rtl/frame_serializer_pkg.sv
// Shared types and defaults for the frame serializer: sample/frame geometry,
// FIFO depth and the two-state transmit FSM encoding.
package frame_serializer_pkg;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_DEPTH = 2;
    localparam int LOG2N         = $clog2(DEFAULT_N);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [DEFAULT_W-1:0] frame_t [DEFAULT_N];

endpackage

// File: rtl/frame_fifo.sv
// Generic synchronous FIFO with a registered occupancy count and a
// combinational head read, so the consumer sees the oldest entry directly.
module frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_reg == '0);
    assign push_ok   = push && (count_reg != CNT_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: buffers whole frames and streams them one sample per cycle,
// aligned to the sink's frame-boundary pulse. FRAME_SERIALIZER_EXPECT_EN adds
// the exp_valid/exp_avg/exp_diff expected-result outputs.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_frame,
    input  logic           sink_done,
    output logic [W-1:0]   ser_out,
    output logic           ser_valid,
    output logic           busy,
    output logic [7:0]     underrun_cnt,
    output logic [7:0]     resync_cnt
`ifdef FRAME_SERIALIZER_EXPECT_EN
    ,
    output logic           exp_valid,
    output logic [W-1:0]   exp_avg,
    output logic [W-1:0]   exp_diff
`endif
);

    localparam int LG    = $clog2(N);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [N*W-1:0]   head_frame;
    logic [W-1:0]     head_sample [N];

    state_t           state_reg;
    logic [LG-1:0]    idx_reg;
    logic [7:0]       underrun_cnt_reg;
    logic [7:0]       resync_cnt_reg;

    logic             start_frame;
    logic             resync;
    logic             underrun;
    logic             last_sample;
    logic             frame_done;

    frame_fifo #(
        .WIDTH (N * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_frame),
        .pop       (fifo_pop),
        .head_data (head_frame),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_split
            assign head_sample[gi] = head_frame[gi*W +: W];
        end
    endgenerate

    // Full-ness comes from the registered count only; a same-cycle pop does not free a slot.
    assign in_ready  = !rst && (fifo_count < CNT_W'(DEPTH));
    assign fifo_push = in_valid && in_ready;

    assign start_frame = (state_reg == IDLE) && sink_done && !fifo_empty;
    assign underrun    = (state_reg == IDLE) && sink_done && fifo_empty;
    assign resync      = (state_reg == SEND) && sink_done;
    assign last_sample = (idx_reg == LG'(N - 1));
    assign frame_done  = (state_reg == SEND) && !sink_done && last_sample;
    assign fifo_pop    = frame_done;

    assign busy         = !rst && (state_reg == SEND);
    assign underrun_cnt = underrun_cnt_reg;
    assign resync_cnt   = resync_cnt_reg;

    always_comb begin
        ser_valid = 1'b0;
        ser_out   = '0;
        if (!rst) begin
            if (start_frame || resync) begin
                ser_valid = 1'b1;
                ser_out   = head_sample[0];
            end else if (state_reg == SEND) begin
                ser_valid = 1'b1;
                ser_out   = head_sample[idx_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            underrun_cnt_reg <= '0;
            resync_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_frame) begin
                        state_reg <= SEND;
                        idx_reg   <= LG'(1);
                    end
                end
                SEND: begin
                    // A boundary pulse mid-frame (even on the last sample) restarts the head frame.
                    if (resync) begin
                        idx_reg <= LG'(1);
                    end else if (last_sample) begin
                        state_reg <= IDLE;
                        idx_reg   <= '0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (underrun && (underrun_cnt_reg != 8'hFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
            end
            if (resync && (resync_cnt_reg != 8'hFF)) begin
                resync_cnt_reg <= resync_cnt_reg + 8'd1;
            end
        end
    end

`ifdef FRAME_SERIALIZER_EXPECT_EN
    localparam int SUM_W = W + LG;

    logic [SUM_W-1:0] acc_reg;
    logic [SUM_W-1:0] final_sum;
    logic [W-1:0]     avg_calc;
    logic [W-1:0]     last_val;
    logic             exp_valid_reg;
    logic [W-1:0]     exp_avg_reg;
    logic [W-1:0]     exp_diff_reg;

    assign last_val  = head_sample[N-1];
    assign final_sum = acc_reg + SUM_W'(last_val);
    assign avg_calc  = W'(final_sum >> LG);

    // The accumulator reloads on every (re)start, so aborted attempts never reach a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            exp_valid_reg <= 1'b0;
            exp_avg_reg   <= '0;
            exp_diff_reg  <= '0;
        end else begin
            exp_valid_reg <= 1'b0;
            if (start_frame || resync) begin
                acc_reg <= SUM_W'(head_sample[0]);
            end else if (frame_done) begin
                exp_valid_reg <= 1'b1;
                exp_avg_reg   <= avg_calc;
                exp_diff_reg  <= (avg_calc >= last_val) ? (avg_calc - last_val)
                                                        : (last_val - avg_calc);
            end else if (state_reg == SEND) begin
                acc_reg <= acc_reg + SUM_W'(head_sample[idx_reg]);
            end
        end
    end

    assign exp_valid = exp_valid_reg;
    assign exp_avg   = exp_avg_reg;
    assign exp_diff  = exp_diff_reg;
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: a queue-of-frames reference model
// predicts the serial stream; a negedge monitor compares it against the DUT.
`timescale 1ns/1ps
module tb_frame_serializer;
    import frame_serializer_pkg::*;

    localparam int W     = DEFAULT_W;
    localparam int N     = DEFAULT_N;
    localparam int DEPTH = DEFAULT_DEPTH;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_frame;
    logic           sink_done;
    logic [W-1:0]   ser_out;
    logic           ser_valid;
    logic           busy;
    logic [7:0]     underrun_cnt;
    logic [7:0]     resync_cnt;
`ifdef FRAME_SERIALIZER_EXPECT_EN
    logic           exp_valid;
    logic [W-1:0]   exp_avg;
    logic [W-1:0]   exp_diff;
`endif

    always #5 clk = ~clk;

    frame_serializer #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_frame     (in_frame),
        .sink_done    (sink_done),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .busy         (busy),
        .underrun_cnt (underrun_cnt),
        .resync_cnt   (resync_cnt)
`ifdef FRAME_SERIALIZER_EXPECT_EN
        ,
        .exp_valid    (exp_valid),
        .exp_avg      (exp_avg),
        .exp_diff     (exp_diff)
`endif
    );

    typedef struct {
        int           stamp;
        logic [W-1:0] data;
    } samp_t;

    typedef struct {
        int           stamp;
        logic [W-1:0] avg;
        logic [W-1:0] diff;
    } res_t;

    // Written only by the stimulus process; the monitor only reads and advances its own indices.
    samp_t          exp_q[$];
    res_t           res_q[$];
    logic [N*W-1:0] model_q[$];
    logic [N*W-1:0] pending_q[$];
    int             pos = -1;
    int             m_under = 0;
    int             m_resync = 0;
    logic           e_ready = 1'b0;
    logic           e_busy = 1'b0;
    int             e_under = 0;
    int             e_resync = 0;
    int             cyc = 0;
    bit             live = 1'b0;
    int             probe_cyc = -1;
    int             probe_kind = 0;

    int             checks = 0;
    int             errors = 0;
    int             rd_idx = 0;
    int             res_idx = 0;

    function automatic logic [W-1:0] samp(input logic [N*W-1:0] f, input int k);
        return f[k*W +: W];
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    function automatic logic [N*W-1:0] rand_frame();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
        return f;
    endfunction

    // One clock cycle: drive inputs, then advance the reference model across the coming edge.
    task automatic tick(input logic r, input logic sd);
        samp_t s;
        res_t  rs;
        int    sum;
        int    avg;
        int    last;
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        sink_done = sd;
        in_valid  = (pending_q.size() > 0);
        in_frame  = in_valid ? pending_q[0] : (N*W)'($urandom);
        e_ready   = !r && (model_q.size() < DEPTH);
        e_busy    = !r && (pos >= 0);
        e_under   = m_under;
        e_resync  = m_resync;
        if (r) begin
            model_q.delete();
            pos      = -1;
            m_under  = 0;
            m_resync = 0;
        end else begin
            s.stamp = cyc;
            if (pos < 0) begin
                if (sd) begin
                    if (model_q.size() > 0) begin
                        s.data = samp(model_q[0], 0);
                        exp_q.push_back(s);
                        pos = 1;
                    end else if (m_under < 255) begin
                        m_under++;
                    end
                end
            end else if (sd) begin
                s.data = samp(model_q[0], 0);
                exp_q.push_back(s);
                pos = 1;
                if (m_resync < 255) m_resync++;
            end else begin
                s.data = samp(model_q[0], pos);
                exp_q.push_back(s);
                if (pos == N - 1) begin
                    sum = 0;
                    for (int k = 0; k < N; k++) sum += int'(samp(model_q[0], k));
                    avg  = (sum / N) % (1 << W);
                    last = int'(samp(model_q[0], N - 1));
                    rs.stamp = cyc + 1;
                    rs.avg   = W'(avg);
                    rs.diff  = W'((avg > last) ? (avg - last) : (last - avg));
                    res_q.push_back(rs);
                    model_q.delete(0);
                    pos = -1;
                end else begin
                    pos++;
                end
            end
            if (in_valid && e_ready) begin
                model_q.push_back(in_frame);
                pending_q.delete(0);
            end
        end
        live = 1'b1;
    endtask

    // Monitor: compares every cycle's outputs against what the model queued for this cycle.
    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("underrun_cnt", 32'(underrun_cnt), 32'(e_under));
            chk("resync_cnt", 32'(resync_cnt), 32'(e_resync));
            if (rd_idx < exp_q.size() && exp_q[rd_idx].stamp == cyc) begin
                chk("ser_valid", 32'(ser_valid), 32'd1);
                chk("ser_out", 32'(ser_out), 32'(exp_q[rd_idx].data));
                rd_idx++;
            end else begin
                chk("ser_valid_idle", 32'(ser_valid), 32'd0);
                chk("ser_out_idle", 32'(ser_out), 32'd0);
            end
`ifdef FRAME_SERIALIZER_EXPECT_EN
            if (res_idx < res_q.size() && res_q[res_idx].stamp == cyc) begin
                chk("exp_valid", 32'(exp_valid), 32'd1);
                chk("exp_avg", 32'(exp_avg), 32'(res_q[res_idx].avg));
                chk("exp_diff", 32'(exp_diff), 32'(res_q[res_idx].diff));
                res_idx++;
            end else begin
                chk("exp_valid_idle", 32'(exp_valid), 32'd0);
            end
`endif
            if (probe_cyc == cyc) begin
                case (probe_kind)
                    1: chk("underrun_saturated", 32'(underrun_cnt), 32'd255);
                    2: begin
                        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
                        chk("post_reset_busy", 32'(busy), 32'd0);
                    end
                    3: chk("stream_drained", 32'(exp_q.size() - rd_idx), 32'd0);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        logic [N*W-1:0] f;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sink_done = 1'b0;
        in_frame  = '0;
        repeat (3) tick(1'b1, 1'b0);

        // Single frame against a sink pulsing every 4 cycles.
        pending_q.push_back(32'h4030_2010);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, (i % 4) == 0);

        // Three frames with a stalled sink; third waits for the first pop.
        for (int k = 0; k < 3; k++) pending_q.push_back(rand_frame());
        repeat (4) tick(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, (i % 4) == 0);

        // Empty FIFO with sink_done held high: counter saturates.
        repeat (300) tick(1'b0, 1'b1);
        probe_cyc  = cyc;
        probe_kind = 1;
        tick(1'b0, 1'b0);

        // Resync at idx 2.
        pending_q.push_back(rand_frame());
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b0);

        // Reset at idx 1 with a second frame queued.
        pending_q.push_back(rand_frame());
        pending_q.push_back(rand_frame());
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        probe_cyc  = cyc;
        probe_kind = 2;
        repeat (3) tick(1'b0, 1'b1);

        // Sum near the top of range.
        pending_q.push_back(32'h00FF_FFFF);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, (i % 4) == 0);

        // In-sync sink with a busy producer: back-to-back frames.
        for (int i = 0; i < 400; i++) begin
            if (pending_q.size() < 2 && ($urandom % 2) == 0) pending_q.push_back(rand_frame());
            tick(1'b0, (i % 4) == 0);
        end

        // Random sink timing, pushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (pending_q.size() == 0 && ($urandom % 3) == 0) begin
                f = rand_frame();
                pending_q.push_back(f);
            end
            tick(($urandom % 300) == 0, ($urandom % 5) == 0);
        end

        pending_q.delete();
        repeat (3) tick(1'b0, 1'b0);
        probe_cyc  = cyc;
        probe_kind = 3;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Parallel-to-serial sample-frame transmitter that feeds 4-sample, 8-bit frames to the serial averaging/difference unit. It accepts whole frames over a valid/ready handshake and buffers them in a small FIFO. It emits one sample per cycle on the serial bus, aligned to the sink's `done` (frame-boundary) indication. It sits between the frame producer and the averager's `ser_in`/`done` pins.

## Interface
- `W`, default 8: sample width in bits.
- `N`, default 4: samples per frame; must be a power of two, at least 2.
- `DEPTH`, default 2: frame FIFO depth in whole frames.
- `clk`  input  1  clock; all logic is rising-edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  producer presents a frame.
- `in_ready`  output  1  FIFO can accept a frame; `in_valid && in_ready` pushes.
- `in_frame`  input  N*W  frame; sample k is `in_frame[k*W +: W]`, with sample 0 sent first.
- `sink_done`  input  1  sink is at a frame boundary and samples sample 0 this cycle.
- `ser_out`  output  W  serial sample to the sink's `ser_in`.
- `ser_valid`  output  1  `ser_out` carries real frame data.
- `busy`  output  1  a frame is in flight (SEND state).
- `underrun_cnt`  output  8  saturating count of `sink_done` cycles with an empty FIFO.
- `resync_cnt`  output  8  saturating count of frames restarted because `sink_done` arrived mid-frame.

## Operation
- Frame FIFO:
  - `in_ready = (count < DEPTH)`, driven from registered count; it is not relieved by a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
- FSM has two states, IDLE and SEND, with sample index `idx` (log2 N bits).
- IDLE, `sink_done=1`, FIFO non-empty:
  - `ser_out` = head sample 0 and `ser_valid=1`, both combinational from head and `idx=0`.
  - Next state SEND, `idx=1`.
- IDLE, `sink_done=1`, FIFO empty:
  - `ser_out=0`, `ser_valid=0`.
  - `underrun_cnt` increments, saturating at 255.
  - State stays IDLE.
- IDLE, `sink_done=0`: `ser_out=0`, `ser_valid=0`.
- SEND, `sink_done=0`:
  - Output head sample `idx` with `ser_valid=1`.
  - If `idx==N-1`: pop the head, go to IDLE, `idx=0`. Otherwise `idx` increments.
- SEND, `sink_done=1` (sink lost sync, e.g. it was reset):
  - Restart the same head frame: output sample 0 and set `idx=1`.
  - `resync_cnt` increments, saturating at 255.
  - No pop.
- `sink_done` in the same cycle as the last sample (`idx==N-1`) is treated as a resync, not a completion.
- Reset (including mid-frame):
  - FIFO is emptied and the in-flight frame is dropped.
  - State returns to IDLE, `idx=0`, both counters are cleared.
  - While `rst` is high: `in_ready=0`, `ser_valid=0`, `ser_out=0`, `busy=0`.

## Timing
- The serial path is combinational from registered state and FIFO head to `ser_out`; there are no input-to-output combinational paths except `sink_done` to `ser_out`/`ser_valid`.
- Against an in-sync sink, a frame occupies exactly N consecutive cycles, starting in the cycle `sink_done=1`.
- Back-to-back frames run with zero gap: the sink's `done` reasserts in the cycle after sample N-1.
- Push-to-first-sample latency is at least 1 cycle: a frame pushed at edge t can be sent from cycle t+1 if `sink_done` is high.
- `busy` = (state == SEND), registered.

## Configuration
- `FRAME_SERIALIZER_EXPECT_EN` defined adds three outputs: `exp_valid` (1), `exp_avg` (W), `exp_diff` (W).
  - On each completed frame, `sum` = total of the N samples (W+log2 N bits, no overflow).
  - `exp_avg = (sum >> log2 N)` truncated to W bits.
  - `exp_diff = |exp_avg - sample[N-1]|`.
  - All three are registered on the edge that pops the frame; `exp_valid` pulses for 1 cycle, aligned with the sink's avg/diff output update.
  - Resynced (restarted) frames produce no result for the aborted attempt.
  - A partial sum register accumulates as samples are sent.
- Undefined: these ports and the accumulation logic are absent.

## Structure
- Package `frame_serializer_pkg` holds:
  - the default W, N, DEPTH and derived LOG2N;
  - the state enum {IDLE, SEND};
  - the frame typedef (array of N W-bit samples).
- Sub-module `frame_fifo`: a generic synchronous FIFO with a registered count. The FSM, counters and expectation logic live in the top module.

## Test plan
- Push {0x10,0x20,0x30,0x40}, then `sink_done` pulse every 4 cycles -> `ser_out` 0x10,0x20,0x30,0x40 with `ser_valid=1`; with macro defined, `exp_avg=0x28`, `exp_diff=0x18`, `exp_valid` for 1 cycle.
- Push 3 frames while `sink_done=0` -> `in_ready` drops after 2; the third is accepted only after the first frame's pop; the stream is ordered and gapless.
- `sink_done` held high with an empty FIFO for 300 cycles -> `ser_valid=0`, `ser_out=0`, `underrun_cnt` saturates at 255.
- `sink_done` asserted at `idx=2` -> sample 0 is resent, `resync_cnt=1`, frame is not popped, 4 full samples follow.
- `rst` at `idx=1` with a second frame queued -> next cycle count is 0, `in_ready=1`, `busy=0`, and no stale sample on later `sink_done`.
- Frame {0xFF,0xFF,0xFF,0x00} -> `exp_avg=0xBF`, `exp_diff=0xBF`; the sum 0x2FD does not overflow.
